// File: rtl/garbage_inbox.sv
// Purpose: versus-mode garbage inbox. Queues opponent attack packets, arms each one after a delay, and offers the armed total to the local board.
// Latency: a push shows in pending_total after its edge and in attacked DELAY_CYC+1 edges later (1 edge when GARBAGE_DELAY_EN is undefined).
// Backpressure: none upstream. A packet that arrives while the queue is full is dropped and overflow pulses for one cycle.
// Build option: define GARBAGE_DELAY_EN to enable the per-entry arming timers. Without it, every entry is armed as soon as it is pushed.
module garbage_inbox #(
  parameter int DEPTH     = 8,
  parameter int DELAY_CYC = 50_000_000,
  parameter int MAX_ATK   = 20
) (
  input  logic       clk,
  input  logic       rst,
  input  logic       atk_valid,
  input  logic [2:0] atk_lines,
  input  logic       hold,
  input  logic       commit,
  output logic [4:0] attacked,
  output logic [4:0] pending_total,
  output logic       armed_any,
  output logic       overflow
);
  localparam int PW = $clog2(DEPTH);
  localparam int CW = PW + 1;
  localparam int SW = 8;
`ifdef GARBAGE_DELAY_EN
  localparam int TW = $clog2(DELAY_CYC + 1);
`endif

  logic [2:0]    lines_q [DEPTH];
  logic [2:0]    lines_n [DEPTH];
`ifdef GARBAGE_DELAY_EN
  logic [TW-1:0] timer_q [DEPTH];
  logic [TW-1:0] timer_n [DEPTH];
`endif
  logic [PW-1:0] head_q, head_n, tail_q, tail_n, idx;
  logic [CW-1:0] count_q, count_n;
  logic [SW-1:0] armed_sum, total;
  logic [4:0]    rem, attacked_n, pending_n;
  logic [2:0]    lines_in;
  logic          stop, armed_any_n, overflow_n;

  function automatic logic [4:0] sat(input logic [SW-1:0] s);
    return (s > SW'(MAX_ATK)) ? 5'(MAX_ATK) : s[4:0];
  endfunction

  // Next-state: armed prefix sum, commit retirement, timer countdown, push, totals.
  always_comb begin
    lines_in = (atk_lines > 3'd4) ? 3'd4 : atk_lines;
    idx = head_q;
    // Armed entries always form a prefix from the head; stop at the first unarmed one.
    armed_sum = '0;
    stop = 1'b0;
    for (int i = 0; i < DEPTH; i++) begin
      idx = head_q + PW'(i);
      if (CW'(i) >= count_q) stop = 1'b1;
`ifdef GARBAGE_DELAY_EN
      if (timer_q[idx] != '0) stop = 1'b1;
`endif
      if (!stop) armed_sum = armed_sum + SW'(lines_q[idx]);
    end

    lines_n = lines_q;
`ifdef GARBAGE_DELAY_EN
    for (int j = 0; j < DEPTH; j++)
      timer_n[j] = (timer_q[j] != '0) ? timer_q[j] - TW'(1) : '0;
`endif
    // Retire exactly the presented amount, oldest first. A leftover amount trims the head entry.
    head_n  = head_q;
    count_n = count_q;
    rem     = commit ? attacked : 5'd0;
    for (int i = 0; i < DEPTH; i++) begin
      idx = head_q + PW'(i);
      if (rem != 5'd0 && CW'(i) < count_q) begin
        if (rem >= {2'b00, lines_q[idx]}) begin
          rem          = rem - {2'b00, lines_q[idx]};
          lines_n[idx] = '0;
`ifdef GARBAGE_DELAY_EN
          timer_n[idx] = '0;
`endif
          head_n       = head_n + PW'(1);
          count_n      = count_n - CW'(1);
        end else begin
          lines_n[idx] = lines_q[idx] - rem[2:0];
          rem          = 5'd0;
        end
      end
    end

    // The push lands after the pops, so a slot freed by the same edge's commit is usable.
    tail_n     = tail_q;
    overflow_n = 1'b0;
    if (atk_valid && lines_in != 3'd0) begin
      if (count_n == CW'(DEPTH)) begin
        overflow_n = 1'b1;
      end else begin
        lines_n[tail_q] = lines_in;
`ifdef GARBAGE_DELAY_EN
        timer_n[tail_q] = TW'(DELAY_CYC);
`endif
        tail_n  = tail_q + PW'(1);
        count_n = count_n + CW'(1);
      end
    end

    // Freed slots hold zero lines, so summing every slot gives the queue total.
    total = '0;
    armed_any_n = 1'b0;
    for (int j = 0; j < DEPTH; j++) begin
      total = total + SW'(lines_n[j]);
`ifdef GARBAGE_DELAY_EN
      if (lines_n[j] != 3'd0 && timer_n[j] == '0) armed_any_n = 1'b1;
`endif
    end
`ifndef GARBAGE_DELAY_EN
    armed_any_n = (count_n != '0);
`endif
    pending_n = sat(total);

    if (commit)     attacked_n = 5'd0;
    else if (!hold) attacked_n = sat(armed_sum);
    else            attacked_n = attacked;
  end

  // State and registered outputs.
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      for (int j = 0; j < DEPTH; j++) begin
        lines_q[j] <= '0;
`ifdef GARBAGE_DELAY_EN
        timer_q[j] <= '0;
`endif
      end
      head_q        <= '0;
      tail_q        <= '0;
      count_q       <= '0;
      attacked      <= '0;
      pending_total <= '0;
      armed_any     <= 1'b0;
      overflow      <= 1'b0;
    end else begin
      lines_q       <= lines_n;
`ifdef GARBAGE_DELAY_EN
      timer_q       <= timer_n;
`endif
      head_q        <= head_n;
      tail_q        <= tail_n;
      count_q       <= count_n;
      attacked      <= attacked_n;
      pending_total <= pending_n;
      armed_any     <= armed_any_n;
      overflow      <= overflow_n;
    end
  end
endmodule

// File: tb/tb_garbage_inbox.sv
module tb_garbage_inbox;
`ifdef GARBAGE_DELAY_EN
  localparam int ARM = 8;
`else
  localparam int ARM = 0;
`endif

  logic       clk = 1'b0;
  logic       rst;
  logic       atk_valid;
  logic [2:0] atk_lines;
  logic       hold;
  logic       commit;
  logic [4:0] attacked;
  logic [4:0] pending_total;
  logic       armed_any;
  logic       overflow;

  garbage_inbox #(.DEPTH(8), .DELAY_CYC(8), .MAX_ATK(20)) dut (
    .clk(clk), .rst(rst), .atk_valid(atk_valid), .atk_lines(atk_lines),
    .hold(hold), .commit(commit), .attacked(attacked),
    .pending_total(pending_total), .armed_any(armed_any), .overflow(overflow)
  );

  always #5 clk = ~clk;

  typedef struct {
    int         cyc;
    logic [4:0] att;
    logic [4:0] pend;
    logic       arm;
    logic       ovf;
  } exp_t;

  exp_t  sb[$];
  string sb_name[$];
  exp_t  e;
  string en;
  int    edge_n = 0;
  int    ntests = 0;
  int    nfail  = 0;
  int    p, c, f;

  task automatic exp_push(input int cy, input string nm, input logic [4:0] a,
                          input logic [4:0] pd, input logic ar, input logic ov);
    exp_t x;
    x.cyc = cy; x.att = a; x.pend = pd; x.arm = ar; x.ovf = ov;
    sb.push_back(x);
    sb_name.push_back(nm);
  endtask

  task automatic cyc(input logic v, input logic [2:0] l, input logic cm);
    atk_valid = v; atk_lines = l; commit = cm;
    @(negedge clk);
    atk_valid = 1'b0; atk_lines = 3'd0; commit = 1'b0;
  endtask

  task automatic idle(input int n);
    for (int i = 0; i < n; i++) cyc(1'b0, 3'd0, 1'b0);
  endtask

  // Monitor: after each rising edge, compare the outputs against any expectation due at that edge.
  initial begin
    forever begin
      @(posedge clk);
      edge_n++;
      #2;
      while (sb.size() > 0 && sb[0].cyc <= edge_n) begin
        e  = sb.pop_front();
        en = sb_name.pop_front();
        ntests++;
        if (e.cyc != edge_n) begin
          nfail++;
          $display("FAIL %s: check for edge %0d not reached in order (now edge %0d)", en, e.cyc, edge_n);
        end else if (attacked !== e.att || pending_total !== e.pend ||
                     armed_any !== e.arm || overflow !== e.ovf) begin
          nfail++;
          $display("FAIL %s @edge %0d: got att=%0d pend=%0d arm=%0b ovf=%0b, want att=%0d pend=%0d arm=%0b ovf=%0b",
                   en, edge_n, attacked, pending_total, armed_any, overflow,
                   e.att, e.pend, e.arm, e.ovf);
        end
      end
    end
  end

  initial begin
    rst = 1'b1; atk_valid = 1'b0; atk_lines = 3'd0; hold = 1'b0; commit = 1'b0;
    exp_push(1, "reset_e1", 0, 0, 0, 0);
    exp_push(2, "reset_e2", 0, 0, 0, 0);
    @(negedge clk);
    @(negedge clk);
    rst = 1'b0;

    // Arming delay for a single 3-line packet.
    p = edge_n + 1;
    exp_push(p,       "arm_push",       0, 3, ARM == 0, 0);
    exp_push(p + ARM, "arm_timer_zero", 0, 3, 1, 0);
    exp_push(p + ARM + 1, "arm_attacked", 3, 3, 1, 0);
    cyc(1, 3, 0);
    idle(ARM + 1);
    c = edge_n + 1;
    exp_push(c,     "commit3_clear", 0, 0, 0, 0);
    exp_push(c + 1, "commit3_idle",  0, 0, 0, 0);
    cyc(0, 0, 1);
    idle(1);

    // Clamp 7->4, zero-line packet ignored, then 4 and 3: total 11 retired by one commit.
    p = edge_n + 1;
    exp_push(p,     "clamp7",       0, 4, ARM == 0, 0);
    exp_push(p + 1, "zero_ignored", (ARM == 0) ? 5'd4 : 5'd0, 4, ARM == 0, 0);
    exp_push(p + 3, "sum_pend",     (ARM == 0) ? 5'd8 : 5'd0, 11, ARM == 0, 0);
    exp_push(p + ARM + 4, "sum_att", 11, 11, 1, 0);
    cyc(1, 7, 0);
    cyc(1, 0, 0);
    cyc(1, 4, 0);
    cyc(1, 3, 0);
    idle(ARM + 1);
    c = edge_n + 1;
    exp_push(c,     "commit11_empty", 0, 0, 0, 0);
    exp_push(c + 1, "commit11_idle",  0, 0, 0, 0);
    cyc(0, 0, 1);
    idle(1);

    // Saturation: six 4s, commit 20, head keeps 4.
    p = edge_n + 1;
    exp_push(p + 5, "sat_pend", (ARM == 0) ? 5'd20 : 5'd0, 20, ARM == 0, 0);
    exp_push(p + ARM + 6, "sat_att", 20, 20, 1, 0);
    repeat (6) cyc(1, 4, 0);
    idle(ARM + 1);
    c = edge_n + 1;
    exp_push(c,     "commit20_head4", 0, 4, 1, 0);
    exp_push(c + 1, "residual_att4",  4, 4, 1, 0);
    exp_push(c + 2, "commit4_empty",  0, 0, 0, 0);
    cyc(0, 0, 1);
    idle(1);
    cyc(0, 0, 1);

    // Partial reduction: seven 3s (21), commit 20 leaves 1 in the head entry.
    p = edge_n + 1;
    exp_push(p + ARM + 7, "sat21_att", 20, 20, 1, 0);
    repeat (7) cyc(1, 3, 0);
    idle(ARM + 1);
    c = edge_n + 1;
    exp_push(c,     "partial_pend1", 0, 1, 1, 0);
    exp_push(c + 1, "partial_att1",  1, 1, 1, 0);
    exp_push(c + 2, "commit1_empty", 0, 0, 0, 0);
    cyc(0, 0, 1);
    idle(1);
    cyc(0, 0, 1);

    // Overflow, push+commit in the same edge, and hold freezing attacked.
    p = edge_n + 1;
    exp_push(p,           "ovf_first",       0, 1, ARM == 0, 0);
    exp_push(p + ARM + 1, "ovf_first_armed", 1, 1, 1, 0);
    cyc(1, 1, 0);
    idle(ARM + 1);
    hold = 1'b1;
    f = edge_n + 7;
    exp_push(f,           "full8",                 1, 8, 1, 0);
    exp_push(f + 1,       "drop_ovf",              1, 8, 1, 1);
    exp_push(f + 2,       "ovf_one_cycle",         1, 8, 1, 0);
    exp_push(f + 3,       "push_commit_same_edge", 0, 10, 1, 0);
    exp_push(f + 4,       "hold_keeps_zero",       0, 10, 1, 0);
    exp_push(f + 4 + ARM, "hold_frozen_armed",     0, 10, 1, 0);
    exp_push(f + 5 + ARM, "hold_release",          10, 10, 1, 0);
    exp_push(f + 6 + ARM, "commit10_empty",        0, 0, 0, 0);
    repeat (7) cyc(1, 1, 0);
    cyc(1, 3, 0);
    idle(1);
    cyc(1, 3, 1);
    idle(1);
    idle(ARM);
    hold = 1'b0;
    cyc(0, 0, 0);
    cyc(0, 0, 1);

    // Reset asserted mid-queue while a commit is in flight.
    p = edge_n + 1;
    exp_push(p + ARM + 2, "pre_reset_att6", 6, 6, 1, 0);
    cyc(1, 2, 0);
    cyc(1, 4, 0);
    idle(ARM + 1);
    exp_push(edge_n + 1, "reset_mid_commit", 0, 0, 0, 0);
    rst = 1'b1;
    commit = 1'b1;
    @(negedge clk);
    commit = 1'b0;
    rst = 1'b0;
    exp_push(edge_n + 1, "post_reset_empty", 0, 0, 0, 0);
    idle(1);
    p = edge_n + 1;
    exp_push(p,           "after_reset_push", 0, 2, ARM == 0, 0);
    exp_push(p + ARM + 1, "after_reset_att2", 2, 2, 1, 0);
    cyc(1, 2, 0);
    idle(ARM + 1);
    exp_push(edge_n + 1, "final_commit_empty", 0, 0, 0, 0);
    cyc(0, 0, 1);
    idle(3);

    while (sb.size() > 0) begin
      e  = sb.pop_front();
      en = sb_name.pop_front();
      ntests++;
      nfail++;
      $display("FAIL %s: check for edge %0d never reached (now edge %0d)", en, e.cyc, edge_n);
    end
    $display("[TB] %0d tests run, %0d failed", ntests, nfail);
    $finish;
  end
endmodule
